apx_add_err_collector: RTL
==========================

Name: apx_add_err_collector

Overview:
Result-side counterpart to the operand stimulus path of the configurable approximate integer adders. It takes each operand pair and the adder's approximate sum over a valid/ready stream. It recomputes the exact sum and accumulates error statistics in hardware: error sum, maximum error, count of erroneous samples and sample count. Sits beside the adder under test, so accuracy runs need no file dumps.

Parameters:
OP_BITWIDTH, 32, operand/result width in bits; all values are signed two's complement.
DATA_PATH_BITWIDTH, 32, width of the adder's data path; carried for parity with the adders; must be >= OP_BITWIDTH.
NUM_SAMPLES, 500, samples accepted per run.
ACC_WIDTH, 48, width of the error-sum accumulator; must be >= OP_BITWIDTH+1.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
in_valid  in  1  a, b, c_apx valid this cycle
in_ready  out  1  collector accepts the sample this cycle
a  in  OP_BITWIDTH  operand a
b  in  OP_BITWIDTH  operand b
c_apx  in  OP_BITWIDTH  approximate sum from the adder under test
err_sum  out  ACC_WIDTH  saturating sum of |exact - c_apx|
err_max  out  OP_BITWIDTH+1  largest single |exact - c_apx|
err_count  out  32  samples with nonzero error
sample_cnt  out  32  samples accepted in the current run
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs and pipeline registers go to 0, including in_ready=0.
  - Deasserting reset mid-run leaves the block in IDLE; the partial run is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: clear err_sum, err_max, err_count and sample_cnt; go to RUN. done drops the next cycle.
  - RUN: in_ready=1. A sample is accepted when in_valid&&in_ready, and sample_cnt increments that cycle.
    - When the accepted sample makes sample_cnt reach NUM_SAMPLES, go to DRAIN. in_ready is 0 from the next cycle.
    - Gaps on in_valid simply stall; there is no timeout.
  - DRAIN: wait until both pipeline stages are empty (2 cycles), then go to DONE.
  - DONE: done=1, busy=0. Statistics hold until the next start.
  - start in RUN or DRAIN is ignored.
- Pipeline:
  - Stage 1 registers exact = a+b, truncated to OP_BITWIDTH with wrap-around (two's complement, no overflow flag). It also registers c_apx and a valid bit.
  - Stage 2 computes diff = sext(exact) - sext(c_apx) in OP_BITWIDTH+1 bits, and err = |diff| as unsigned OP_BITWIDTH+1 bits. It then updates the statistics.
  - Latency: a sample accepted at cycle t is reflected in err_sum, err_max and err_count after the clock edge at t+2.
  - sample_cnt updates at t+1.
- Arithmetic:
  - err_sum += zero-extended err, saturating at all-ones; it never wraps.
  - err_max = max(err_max, err), unsigned compare.
  - err_count increments when err != 0 and wraps at 2^32 (unreachable for legal NUM_SAMPLES).
- in_ready is purely a function of state; it has no combinational path from in_valid.

Decomposition:
- Shared package apx_err_pkg holds:
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - a function for the signed-difference magnitude;
  - the ACC_WIDTH >= OP_BITWIDTH+1 check constant.
- One natural sub-module: apx_err_stat_unit (stage 2: magnitude, saturating accumulate, max, count). The FSM and stage 1 stay in the top level.

Test Plan:
- NUM_SAMPLES=4; start; 4 samples a=5, b=7, c_apx=12 -> err_sum=0, err_max=0, err_count=0, sample_cnt=4; done=1 two cycles after the last accept; in_ready=0 in DRAIN.
- a=100, b=27, c_apx=120, then a=1, b=1, c_apx=0 -> err_sum=9, err_max=7, err_count=2.
- a=32'hFFFFFFFD (-3), b=1, c_apx=0 -> exact=-2, err=2. Then a=32'h7FFFFFFF, b=1, c_apx=32'h80000000 -> err=0 (wrap).
  - Then c_apx=32'h7FFFFFFF on the same operands -> err_max=33'h0FFFFFFFF.
- ACC_WIDTH=33; 3 samples each with err=33'h0FFFFFFFF -> err_sum saturates at 33'h1FFFFFFFF and stays there.
- Reset and stall handling:
  - in_valid toggles every other cycle -> sample_cnt counts only handshakes.
  - start pulsed in RUN -> ignored, counters intact.
  - rst=0 asserted mid-RUN -> all outputs 0 immediately, state IDLE.
  - A new start then runs cleanly from zero.

Source files
------------

// File: rtl/apx_err_pkg.sv
// Shared types and helpers for the approximate-adder error collector.
// Holds the FSM encoding, the difference-magnitude helper and config checks.
package apx_err_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Wide enough for any operand width up to 64 bits plus sign
    localparam int MAG_W = 66;

    function automatic logic [MAG_W-1:0] mag_diff(
        input logic signed [MAG_W-1:0] x,
        input logic signed [MAG_W-1:0] y
    );
        logic signed [MAG_W-1:0] d;
        d = x - y;
        return (d < 0) ? MAG_W'(-d) : MAG_W'(d);
    endfunction

    function automatic bit acc_width_ok(input int op_w, input int acc_w);
        return (acc_w >= op_w + 1) && (op_w <= MAG_W - 2);
    endfunction

endpackage

// File: rtl/apx_add_err_collector_if.sv
// Sample stream from the adder under test: operands plus approximate sum.
// Valid/ready handshake; the collector is the slave side.
interface apx_add_err_collector_if #(
    parameter int OP_BITWIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_BITWIDTH-1:0] a;
    logic [OP_BITWIDTH-1:0] b;
    logic [OP_BITWIDTH-1:0] c_apx;

    modport master (
        output in_valid, a, b, c_apx,
        input  in_ready
    );

    modport slave (
        input  in_valid, a, b, c_apx,
        output in_ready
    );
endinterface

// File: rtl/apx_err_stat_unit.sv
// Stage 2: error magnitude against the exact sum and running statistics.
// Sum saturates at all-ones, max is unsigned, count wraps.
module apx_err_stat_unit
    import apx_err_pkg::*;
#(
    parameter int OP_BITWIDTH = 32,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_vld,
    input  logic [OP_BITWIDTH-1:0] i_exact,
    input  logic [OP_BITWIDTH-1:0] i_capx,
    output logic [ACC_WIDTH-1:0]   o_err_sum,
    output logic [OP_BITWIDTH:0]   o_err_max,
    output logic [31:0]            o_err_count
);

    logic [OP_BITWIDTH:0] w_err;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic [ACC_WIDTH-1:0] w_sum_sat;

    always_comb begin
        w_err = (OP_BITWIDTH+1)'(mag_diff(
            MAG_W'(signed'(i_exact)),
            MAG_W'(signed'(i_capx))));
        w_sum_ext = {1'b0, o_err_sum} + (ACC_WIDTH+1)'(w_err);
        w_sum_sat = w_sum_ext[ACC_WIDTH] ? '1
                                         : w_sum_ext[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_err_sum   <= '0;
            o_err_max   <= '0;
            o_err_count <= '0;
        end else if (i_clr) begin
            o_err_sum   <= '0;
            o_err_max   <= '0;
            o_err_count <= '0;
        end else if (i_vld) begin
            o_err_sum <= w_sum_sat;
            if (w_err > o_err_max)
                o_err_max <= w_err;
            if (w_err != '0)
                o_err_count <= o_err_count + 32'd1;
        end
    end

endmodule

// File: rtl/apx_add_err_collector.sv
// Error collector beside an approximate adder: run FSM plus stage 1
// (exact sum), feeding the statistics unit in stage 2.
module apx_add_err_collector
    import apx_err_pkg::*;
#(
    parameter int OP_BITWIDTH        = 32,
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int NUM_SAMPLES        = 500,
    parameter int ACC_WIDTH          = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    apx_add_err_collector_if.slave   s_bus,
    output logic [ACC_WIDTH-1:0]     err_sum,
    output logic [OP_BITWIDTH:0]     err_max,
    output logic [31:0]              err_count,
    output logic [31:0]              sample_cnt,
    output logic                     busy,
    output logic                     done
);

    generate
        if (!acc_width_ok(OP_BITWIDTH, ACC_WIDTH) ||
            DATA_PATH_BITWIDTH < OP_BITWIDTH) begin : g_bad_cfg
            $error("apx_add_err_collector: illegal width configuration");
        end
    endgenerate

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_done;
    logic [31:0]            r_cnt;
    logic                   r_s1_vld;
    logic [OP_BITWIDTH-1:0] r_s1_exact;
    logic [OP_BITWIDTH-1:0] r_s1_capx;

    logic w_accept;
    logic w_last;
    logic w_clr;

    assign w_accept = s_bus.in_valid && r_in_ready;
    assign w_last   = (r_cnt + 32'd1) == 32'(NUM_SAMPLES);
    assign w_clr    = start &&
                      (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_exact <= '0;
            r_s1_capx  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_exact <= s_bus.a + s_bus.b;
                r_s1_capx  <= s_bus.c_apx;
            end
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 32'd1;
                        if (w_last) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last sample sits in stage 1 and is absorbed this edge
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_bus.in_ready = r_in_ready;
    assign sample_cnt     = r_cnt;
    assign busy           = r_busy;
    assign done           = r_done;

    apx_err_stat_unit #(
        .OP_BITWIDTH (OP_BITWIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_stat (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_vld       (r_s1_vld),
        .i_exact     (r_s1_exact),
        .i_capx      (r_s1_capx),
        .o_err_sum   (err_sum),
        .o_err_max   (err_max),
        .o_err_count (err_count)
    );

endmodule
